// File: rtl/ca_correlator.sv
// rtl/ca_correlator.sv - C/A code despreader, one signed correlation dump per 1023-chip epoch.
// Optional accumulator saturation with sticky ovf when CA_CORR_SAT_EN is defined.
module ca_correlator #(
  parameter int SAMPLE_W = 4,
  parameter int ACC_W    = 16,
  parameter int CODE_LEN = 1023
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       enb,
  input  logic                       chip,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  output logic signed [ACC_W-1:0]    corr_out,
  output logic                       corr_valid,
  output logic [4:0]                 epoch_cnt,
  output logic                       running,
  output logic                       ovf
);

  localparam int CNT_W = $clog2(CODE_LEN);
  localparam logic [CNT_W-1:0] LAST_CHIP = CNT_W'(CODE_LEN - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                    state, state_nxt;
  logic signed [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]          chip_cnt;
  logic signed [SAMPLE_W:0]  s_ext, prod;
  logic signed [ACC_W:0]     sum_wide;
  logic signed [ACC_W-1:0]   sum;
  logic                      clamp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start) state_nxt = RUN;
  end

  assign running = (state == RUN);

  // One extra bit so that negating the most negative sample cannot wrap.
  assign s_ext    = {sample_in[SAMPLE_W-1], sample_in};
  assign prod     = chip ? s_ext : -s_ext;
  assign sum_wide = {acc[ACC_W-1], acc} + {{(ACC_W-SAMPLE_W){prod[SAMPLE_W]}}, prod};

`ifdef CA_CORR_SAT_EN
  always_comb begin
    clamp = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    sum   = sum_wide[ACC_W-1:0];
    if (clamp) sum = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  end
`else
  logic unused_carry;
  assign unused_carry = sum_wide[ACC_W];
  assign clamp        = 1'b0;
  assign sum          = sum_wide[ACC_W-1:0];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc        <= '0;
      chip_cnt   <= '0;
      corr_out   <= '0;
      corr_valid <= 1'b0;
      epoch_cnt  <= '0;
      ovf        <= 1'b0;
    end else begin
      corr_valid <= 1'b0;
      if (start) begin
        acc       <= '0;
        chip_cnt  <= '0;
        epoch_cnt <= '0;
        ovf       <= 1'b0;
      end else if (state == RUN && enb) begin
        if (clamp) ovf <= 1'b1;
        if (chip_cnt == LAST_CHIP) begin
          corr_out   <= sum;
          corr_valid <= 1'b1;
          acc        <= '0;
          chip_cnt   <= '0;
          epoch_cnt  <= (epoch_cnt == 5'd19) ? 5'd0 : epoch_cnt + 5'd1;
        end else begin
          acc      <= sum;
          chip_cnt <= chip_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ca_correlator.sv
// tb/tb_ca_correlator.sv - directed checks of ca_correlator (ACC_W=16 and a shared-stimulus ACC_W=12 copy).
module tb_ca_correlator;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              enb = 1'b0;
  logic              chip = 1'b0;
  logic signed [3:0] sample_in = '0;

  logic signed [15:0] corr_out;
  logic               corr_valid;
  logic [4:0]         epoch_cnt;
  logic               running;
  logic               ovf;

  logic signed [11:0] corr_out_12;
  logic               corr_valid_12;
  logic [4:0]         epoch_cnt_12;
  logic               running_12;
  logic               ovf_12;

  int n_checks = 0;
  int n_errors = 0;
  int vcnt = 0;
  int v0;

  always #5 clk = ~clk;

  ca_correlator #(.SAMPLE_W(4), .ACC_W(16), .CODE_LEN(1023)) dut (
    .clk(clk), .rst(rst), .start(start), .enb(enb), .chip(chip), .sample_in(sample_in),
    .corr_out(corr_out), .corr_valid(corr_valid), .epoch_cnt(epoch_cnt),
    .running(running), .ovf(ovf)
  );

  ca_correlator #(.SAMPLE_W(4), .ACC_W(12), .CODE_LEN(1023)) dut12 (
    .clk(clk), .rst(rst), .start(start), .enb(enb), .chip(chip), .sample_in(sample_in),
    .corr_out(corr_out_12), .corr_valid(corr_valid_12), .epoch_cnt(epoch_cnt_12),
    .running(running_12), .ovf(ovf_12)
  );

  always @(posedge clk) if (corr_valid === 1'b1) vcnt++;

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int s, input bit c, input int gap);
    enb = 1'b0;
    repeat (gap) step();
    enb       = 1'b1;
    sample_in = s[3:0];
    chip      = c;
    step();
    enb = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    bit c;
    repeat (3) step();
    check("rst_corr_out", corr_out, 0);
    check("rst_valid", corr_valid, 0);
    check("rst_epoch", epoch_cnt, 0);
    check("rst_running", running, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b1;
    step();

    // IDLE ignores strobes
    v0 = vcnt;
    for (int i = 0; i < 10; i++) strobe(3, 1'b1, 0);
    check("idle_running", running, 0);
    check("idle_no_valid", vcnt - v0, 0);

    // back-to-back +3 chip=1
    pulse_start();
    check("start_running", running, 1);
    v0 = vcnt;
    for (int i = 0; i < 1023; i++) strobe(3, 1'b1, 0);
    check("t1_valid", corr_valid, 1);
    check("t1_corr", corr_out, 3069);
    check("t1_epoch", epoch_cnt, 1);
    step();
    check("t1_valid_drop", corr_valid, 0);
    check("t1_pulses", vcnt - v0, 1);

    // +/-1 matched to chip, strobe every 4th cycle
    for (int i = 0; i < 1022; i++) begin
      c = 1'($urandom_range(0, 1));
      strobe(c ? 1 : -1, c, 3);
    end
    check("t2_no_early", corr_valid, 0);
    c = 1'b0;
    strobe(-1, c, 3);
    check("t2_valid", corr_valid, 1);
    check("t2_corr", corr_out, 1023);
    check("t2_epoch", epoch_cnt, 2);

    // 20 epochs, epoch counter wraps
    pulse_start();
    check("t3_epoch_clr", epoch_cnt, 0);
    v0 = vcnt;
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < 1023; i++) strobe(1, 1'b1, 0);
      check($sformatf("t3_epoch_%0d", k), epoch_cnt, (k + 1) % 20);
    end
    step();
    check("t3_pulses", vcnt - v0, 20);
    check("t3_corr", corr_out, 1023);

    // restart at chip 500 coincident with enb
    pulse_start();
    v0 = vcnt;
    for (int i = 0; i < 500; i++) strobe(5, 1'b1, 0);
    start = 1'b1;
    strobe(5, 1'b1, 0);
    start = 1'b0;
    for (int i = 0; i < 1022; i++) strobe(2, 1'b0, 0);
    check("t4_no_valid", vcnt - v0, 0);
    check("t4_no_valid_now", corr_valid, 0);
    strobe(2, 1'b0, 0);
    check("t4_valid", corr_valid, 1);
    check("t4_corr", corr_out, -2046);
    check("t4_epoch", epoch_cnt, 1);

    // async reset mid-epoch
    for (int i = 0; i < 300; i++) strobe(1, 1'b1, 0);
    #2 rst = 1'b0;
    #1;
    check("t4_rst_corr", corr_out, 0);
    check("t4_rst_valid", corr_valid, 0);
    check("t4_rst_epoch", epoch_cnt, 0);
    check("t4_rst_running", running, 0);
    check("t4_rst_ovf", ovf, 0);
    step();
    rst = 1'b1;
    v0 = vcnt;
    for (int i = 0; i < 1023; i++) strobe(1, 1'b1, 0);
    step();
    check("t4_no_resume", vcnt - v0, 0);
    check("t4_still_idle", running, 0);
    check("t4_corr_held0", corr_out, 0);

    // +7 full epoch: 7161 at 16 bits, saturates or wraps at 12 bits
    pulse_start();
    for (int i = 0; i < 1023; i++) strobe(7, 1'b1, 0);
    check("t5_corr16", corr_out, 7161);
    check("t5_ovf16", ovf, 0);
`ifdef CA_CORR_SAT_EN
    check("t5_corr12", corr_out_12, 2047);
    check("t5_ovf12", ovf_12, 1);
`else
    check("t5_corr12", corr_out_12, -1031);
    check("t5_ovf12", ovf_12, 0);
`endif
    check("t5_valid12", corr_valid_12, 1);

    // most negative sample with chip=0
    pulse_start();
    check("t6_ovf12_clr", ovf_12, 0);
    for (int i = 0; i < 1023; i++) strobe(-8, 1'b0, 0);
    check("t6_corr", corr_out, 8184);
    check("t6_ovf", ovf, 0);
    check("t6_valid", corr_valid, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
